// File: rtl/approx_add_pipe.sv
// Two-stage pipelined adder with lower-part-OR approximation.
// Low half plus mid carry in s1, high half plus cout in s2.
module approx_add_pipe #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             approx_flag
);

  localparam int L  = WIDTH / 2;
  localparam int H  = WIDTH - L;
  localparam int K  = APPROX_BITS;
  localparam int KI = (K > 0) ? K - 1 : 0;
  localparam bit AX = (K > 0);

  typedef struct packed {
    logic [L-1:0] lo;
    logic         c;
    logic [H-1:0] ah;
    logic [H-1:0] bh;
    logic         flag;
  } s1_t;

  s1_t          s1_q;
  s1_t          s1_d;
  logic         s1_valid;
  logic         s2_valid;
  logic         s1_adv;
  logic         s2_adv;

  logic [L-1:0] a_lo;
  logic [L-1:0] b_lo;
  logic [L-1:0] kmask;
  logic [L-1:0] lo_or;
  logic [L:0]   cvec;
  logic [L:0]   lo_res;
  logic         use_ax;
  logic         cg;
  logic [H:0]   hi_res;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_valid = s2_valid;

  always_comb begin
    for (int i = 0; i < L; i++) begin
      kmask[i] = (i < K);
    end
  end

  // Approx mode: masked-off upper low bits add with the generated
  // carry injected at bit K; the OR'd bits fill the zeroed LSBs.
  always_comb begin
    use_ax = approx_en & AX;
    cg     = a[KI] & b[KI];
    a_lo   = a[L-1:0];
    b_lo   = b[L-1:0];
    if (use_ax) begin
      lo_or  = (a_lo | b_lo) & kmask;
      cvec   = {{L{1'b0}}, cg} << K;
      lo_res = {1'b0, a_lo & ~kmask}
             + {1'b0, b_lo & ~kmask}
             + cvec;
    end else begin
      lo_or  = '0;
      cvec   = {{L{1'b0}}, cin};
      lo_res = {1'b0, a_lo} + {1'b0, b_lo} + cvec;
    end
    s1_d.lo   = lo_res[L-1:0] | lo_or;
    s1_d.c    = lo_res[L];
    s1_d.ah   = a[WIDTH-1:L];
    s1_d.bh   = b[WIDTH-1:L];
    s1_d.flag = use_ax;
  end

  assign hi_res = {1'b0, s1_q.ah}
                + {1'b0, s1_q.bh}
                + {{H{1'b0}}, s1_q.c};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_q        <= '0;
      s2_valid    <= 1'b0;
      sum         <= '0;
      cout        <= 1'b0;
      approx_flag <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        s1_q     <= s1_d;
      end
      if (s2_adv) begin
        s2_valid    <= s1_valid;
        sum         <= {hi_res[H-1:0], s1_q.lo};
        cout        <= hi_res[H];
        approx_flag <= s1_q.flag;
      end
    end
  end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Bench for approx_add_pipe: directed cases, random stream,
// backpressure and mid-flight reset against a behavioural model.
module tb_approx_add_pipe;

  localparam int W = 16;
  localparam int K = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         approx_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         approx_flag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  approx_add_pipe #(.WIDTH(W), .APPROX_BITS(K)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .approx_en(approx_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .approx_flag(approx_flag)
  );

  // {approx_flag, cout, sum} from plain integer arithmetic
  function automatic logic [17:0] ref_add(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        c,
    input logic        m
  );
    int unsigned xi, yi, r, lo, up, cg;
    xi = x;
    yi = y;
    if (m && K > 0) begin
      lo = (xi | yi) % (1 << K);
      cg = (xi >> (K - 1)) & (yi >> (K - 1)) & 1;
      up = (xi >> K) + (yi >> K) + cg;
      r  = (up << K) + lo;
      return {1'b1, r[16:0]};
    end
    r = xi + yi + 32'(c);
    return {1'b0, r[16:0]};
  endfunction

  task automatic drive(
    input logic        v,
    input logic [15:0] ai,
    input logic [15:0] bi,
    input logic        ci,
    input logic        m
  );
    in_valid  = v;
    a         = ai;
    b         = bi;
    cin       = ci;
    approx_en = m;
  endtask

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
    edge1();
    edge1();
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0 ||
        cout !== 1'b0 || approx_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b s=%h c=%b f=%b want 0",
               out_valid, sum, cout, approx_flag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      edge1();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_accept got %b want 0", out_valid);
      end
    end
  endtask

  task automatic run_single(
    input string       nm,
    input logic [15:0] ai,
    input logic [15:0] bi,
    input logic        ci,
    input logic        m,
    input logic [15:0] es,
    input logic        ec,
    input logic        ef
  );
    out_ready = 1'b1;
    drive(1'b1, ai, bi, ci, m);
    edge1();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid got %b want 0", nm, out_valid);
    end
    edge1();
    checks++;
    if (out_valid !== 1'b1 || sum !== es ||
        cout !== ec || approx_flag !== ef) begin
      errors++;
      $display("FAIL %s got v=%b s=%h c=%b f=%b want 1 %h %b %b",
               nm, out_valid, sum, cout, approx_flag, es, ec, ef);
    end
    edge1();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s dup_valid got %b want 0", nm, out_valid);
    end
  endtask

  task automatic test_exact;
    out_ready = 1'b1;
    drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL exact_in_ready got %b want 1", in_ready);
    end
    edge1();
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL exact_latency got %b want 0", out_valid);
    end
    edge1();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || sum !== 16'h0100 ||
        cout !== 1'b0 || approx_flag !== 1'b0) begin
      errors++;
      $display("FAIL exact_1 got v=%b s=%h c=%b f=%b want 1 0100 0 0",
               out_valid, sum, cout, approx_flag);
    end
    edge1();
    checks++;
    if (out_valid !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1) begin
      errors++;
      $display("FAIL exact_2 got v=%b s=%h c=%b want 1 0000 1",
               out_valid, sum, cout);
    end
    edge1();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL exact_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_approx;
    run_single("approx_cin", 16'h000F, 16'h0001, 1'b1, 1'b1,
               16'h000F, 1'b0, 1'b1);
    run_single("approx_gen", 16'h0008, 16'h0008, 1'b0, 1'b1,
               16'h0018, 1'b0, 1'b1);
    run_single("approx_cout", 16'h8008, 16'h8008, 1'b0, 1'b1,
               16'h0018, 1'b1, 1'b1);
  endtask

  task automatic test_stream;
    logic [17:0] exp_q[$];
    int          cyc_q[$];
    logic [17:0] e;
    int          pc;
    int          sent = 0;
    int          got = 0;
    logic [15:0] ra, rb;
    logic        rc, rm;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (sent < 20) begin
        ra = 16'($urandom());
        rb = 16'($urandom());
        rc = 1'($urandom());
        rm = 1'(sent % 2);
        drive(1'b1, ra, rb, rc, rm);
      end else begin
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      end
      #1;
      if (c >= 2 && c < 22) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_gap cyc=%0d got %b want 1",
                   c, out_valid);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra cyc=%0d got s=%h want none",
                   c, sum);
        end else begin
          e  = exp_q.pop_front();
          pc = cyc_q.pop_front();
          got++;
          if ({approx_flag, cout, sum} !== e || c - pc != 2) begin
            errors++;
            $display("FAIL stream cyc=%0d got %h lat=%0d want %h lat=2",
                     c, {approx_flag, cout, sum}, c - pc, e);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(ref_add(a, b, cin, approx_en));
        cyc_q.push_back(c);
        sent++;
      end
      edge1();
    end
    checks++;
    if (got != 20 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_count got %0d left %0d want 20 0",
               got, exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_t1_ready got %b want 1", in_ready);
    end
    edge1();
    drive(1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_t2_ready got %b want 1", in_ready);
    end
    edge1();
    drive(1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          sum !== 16'h0002) begin
        errors++;
        $display("FAIL bp_full got r=%b v=%b s=%h want 0 1 0002",
                 in_ready, out_valid, sum);
      end
      edge1();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || sum !== 16'h0002) begin
      errors++;
      $display("FAIL bp_release got r=%b s=%h want 1 0002",
               in_ready, sum);
    end
    edge1();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || sum !== 16'h0004) begin
      errors++;
      $display("FAIL bp_out2 got v=%b s=%h want 1 0004",
               out_valid, sum);
    end
    edge1();
    checks++;
    if (out_valid !== 1'b1 || sum !== 16'h0006) begin
      errors++;
      $display("FAIL bp_out3 got v=%b s=%h want 1 0006",
               out_valid, sum);
    end
    edge1();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    edge1();
    drive(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b1);
    edge1();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 16'h5555, 16'h5555, 1'b0, 1'b0);
    edge1();
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0 ||
        cout !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got v=%b s=%h c=%b r=%b want 0 0 0 1",
               out_valid, sum, cout, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      edge1();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_flushed got %b want 0", out_valid);
      end
    end
    run_single("rst_after", 16'h1234, 16'h4321, 1'b1, 1'b0,
               16'h5556, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_exact();
    test_approx();
    test_stream();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
